mem_line_responder: RTL

//  Main-memory model; the responder end of the cache-line fill/writeback interface.
//  - Accepts one line-granular read or write request at a time from the cache miss path.
//  - Applies the package request and response delays, then returns a full line or a write ack.
//  - Sits below the I-cache and D-cache arbiter and stands in for DRAM in simulation.

---
 rtl/mem_line_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_line_responder.sv
// mem_line_responder
//   Main-memory model at the responder end of the cache-line fill/writeback
//   interface. It accepts one line-granular read or write at a time, waits
//   REQ_DELAY cycles before touching the array, then waits RESP_DELAY more
//   cycles before presenting the response. The response is held until it is
//   accepted.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   req_valid   in   request present
//   req_ready   out  responder idle and able to accept a request
//   req_we      in   1 = line write, 0 = line read
//   req_addr    in   byte address; the low log2(LINE_W/8) bits are ignored
//   req_wdata   in   full-line write data
//   resp_valid  out  response present
//   resp_ready  in   requester accepts the response
//   resp_rdata  out  read line data; 0 for writes and for error responses
//   resp_err    out  address out of range (bound-check builds only)
//
// Build option
//   MEM_BOUND_CHECK_EN : any set address bit above the line index marks the
//   request as an error. An error write leaves the array untouched, and an
//   error response returns zero data. When the option is not defined, upper
//   address bits alias modulo MEM_LINES and resp_err is always 0.
module mem_line_responder #(
   parameter int ADDR_W     = 32,
   parameter int LINE_W     = 128,
   parameter int MEM_LINES  = 1024,
   parameter int REQ_DELAY  = 5,
   parameter int RESP_DELAY = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LINE_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [LINE_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int OFF   = $clog2(LINE_W / 8);
   localparam int IDX_W = $clog2(MEM_LINES);
   localparam int MAXD  = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
   localparam int CNT_W = (MAXD > 1) ? $clog2(MAXD) : 1;

   typedef enum logic [1:0] {IDLE, REQ_WAIT, RESP_WAIT, RESP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               lat_we;
   logic               lat_err;
   logic [IDX_W-1:0]   lat_idx;
   logic [LINE_W-1:0]  lat_wdata;

   // Contents are deliberately left unreset, like real DRAM.
   logic [LINE_W-1:0]  mem [MEM_LINES];

   logic [IDX_W-1:0]   idx_in;
   logic               err_in;
   logic               access;
   logic               commit;

   assign idx_in = req_addr[OFF +: IDX_W];

`ifdef MEM_BOUND_CHECK_EN
   assign err_in = (req_addr >> (OFF + IDX_W)) != '0;
`else
   // Upper and offset bits are intentionally dropped, so addresses alias.
   logic addr_unused;
   assign addr_unused = ^req_addr;
   assign err_in      = 1'b0;
`endif

   // The array is accessed on the last REQ_WAIT cycle.
   assign access = (state == REQ_WAIT) && (cnt == '0);
   assign commit = access && lat_we && !lat_err;

   // A reset at the commit edge discards the write.
   always_ff @(posedge clk) begin
      if (commit && !reset)
         mem[lat_idx] <= lat_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         lat_we     <= 1'b0;
         lat_err    <= 1'b0;
         lat_idx    <= '0;
         lat_wdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_we    <= req_we;
                  lat_err   <= err_in;
                  lat_idx   <= idx_in;
                  lat_wdata <= req_wdata;
                  cnt       <= CNT_W'(REQ_DELAY - 1);
                  req_ready <= 1'b0;
                  state     <= REQ_WAIT;
               end
            end
            REQ_WAIT: begin
               if (cnt == '0) begin
                  resp_err   <= lat_err;
                  resp_rdata <= (lat_we || lat_err) ? '0 : mem[lat_idx];
                  cnt        <= CNT_W'(RESP_DELAY - 1);
                  state      <= RESP_WAIT;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP_WAIT: begin
               if (cnt == '0) begin
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               // Data and error flag are held here until the handshake.
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
